// File: rtl/player_mover.sv
`default_nettype none
// ============================================================================
//  Module      : player_mover
//  Description : Moves a player one tile at a time on a bounded
//                MAP_WIDTH x MAP_HEIGHT grid. A request is accepted with a
//                valid/ready handshake. It is checked against the map edges
//                for one cycle (EVAL). A successful move then locks out new
//                requests for COOLDOWN cycles (WAIT).
//  Ports       : clk        - clock, all state changes on the rising edge
//                rst        - synchronous active-high reset
//                spawn      - teleport to (START_X, START_Y), abort request
//                move_valid - a move request is present
//                move_dir   - 0 = left, 1 = down, 2 = up, 3 = right
//                move_ready - registered, high exactly when IDLE
//                pos_x      - current column (registered)
//                pos_y      - current row, row 0 is the top (registered)
//                moved      - one-cycle pulse, position has just changed
//                blocked    - one-cycle pulse, request hit a map edge
//  Revision    : 1.0 - initial release
// ============================================================================
module player_mover #(
    parameter int MAP_WIDTH  = 10,
    parameter int MAP_HEIGHT = 10,
    parameter int START_X    = 0,
    parameter int START_Y    = 0,
    parameter int COOLDOWN   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       spawn,
    input  logic       move_valid,
    input  logic [1:0] move_dir,
    output logic       move_ready,
    output logic [3:0] pos_x,
    output logic [3:0] pos_y,
    output logic       moved,
    output logic       blocked
);

    localparam logic [3:0] c_max_x    = 4'(MAP_WIDTH - 1);
    localparam logic [3:0] c_max_y    = 4'(MAP_HEIGHT - 1);
    localparam logic [3:0] c_start_x  = 4'(START_X);
    localparam logic [3:0] c_start_y  = 4'(START_Y);
    localparam logic [7:0] c_cooldown = 8'(COOLDOWN);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_WAIT = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_dir;
    logic [7:0] r_cnt;
    logic [3:0] r_pos_x;
    logic [3:0] r_pos_y;
    logic       r_ready;
    logic       r_moved;
    logic       r_blocked;

    // Bit order matches move_dir encoding: {right, up, down, left}.
    logic [3:0] w_allow;

    assign w_allow = {
        (r_pos_x != c_max_x),
        (r_pos_y != 4'd0),
        (r_pos_y != c_max_y),
        (r_pos_x != 4'd0)
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_dir     <= 2'd0;
            r_cnt     <= 8'd0;
            r_pos_x   <= c_start_x;
            r_pos_y   <= c_start_y;
            r_ready   <= 1'b1;
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;
        end else begin
            // Result flags are single-cycle pulses by default.
            r_moved   <= 1'b0;
            r_blocked <= 1'b0;

            if (spawn) begin
                // Spawn wins over everything except reset and drops any
                // request in flight or offered this cycle.
                r_state <= S_IDLE;
                r_cnt   <= 8'd0;
                r_pos_x <= c_start_x;
                r_pos_y <= c_start_y;
                r_ready <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (move_valid && r_ready) begin
                            r_dir   <= move_dir;
                            r_state <= S_EVAL;
                            r_ready <= 1'b0;
                        end
                    end

                    S_EVAL: begin
                        if (w_allow[r_dir]) begin
                            case (r_dir)
                                2'd0:    r_pos_x <= r_pos_x - 4'd1;
                                2'd1:    r_pos_y <= r_pos_y + 4'd1;
                                2'd2:    r_pos_y <= r_pos_y - 4'd1;
                                default: r_pos_x <= r_pos_x + 4'd1;
                            endcase
                            r_moved <= 1'b1;
                            if (c_cooldown == 8'd0) begin
                                r_state <= S_IDLE;
                                r_ready <= 1'b1;
                            end else begin
                                r_state <= S_WAIT;
                                r_cnt   <= c_cooldown;
                            end
                        end else begin
                            // Edge hit: no lockout, straight back to IDLE.
                            r_blocked <= 1'b1;
                            r_state   <= S_IDLE;
                            r_ready   <= 1'b1;
                        end
                    end

                    S_WAIT: begin
                        // Counter holds the remaining WAIT cycles including
                        // the current one, so leave when it reaches 1.
                        if (r_cnt <= 8'd1) begin
                            r_cnt   <= 8'd0;
                            r_state <= S_IDLE;
                            r_ready <= 1'b1;
                        end else begin
                            r_cnt <= r_cnt - 8'd1;
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_cnt   <= 8'd0;
                    end
                endcase
            end
        end
    end

    assign move_ready = r_ready;
    assign pos_x      = r_pos_x;
    assign pos_y      = r_pos_y;
    assign moved      = r_moved;
    assign blocked    = r_blocked;

endmodule
`default_nettype wire

// File: tb/tb_player_mover.sv
`default_nettype none
// ============================================================================
//  Module      : tb_player_mover
//  Description : Self-checking bench for player_mover. A table of move
//                requests with their expected outcome feeds a scoreboard
//                queue. Hand-written sequences cover streaming requests,
//                spawn and reset in mid-operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_player_mover;

    localparam int W  = 10;
    localparam int H  = 10;
    localparam int CD = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       spawn = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] move_dir = 2'd0;
    logic       move_ready;
    logic [3:0] pos_x;
    logic [3:0] pos_y;
    logic       moved;
    logic       blocked;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [1:0] dir;
        logic       exp_moved;
        logic [3:0] exp_x;
        logic [3:0] exp_y;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];

    player_mover #(
        .MAP_WIDTH (W),
        .MAP_HEIGHT(H),
        .START_X   (0),
        .START_Y   (0),
        .COOLDOWN  (CD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .spawn     (spawn),
        .move_valid(move_valid),
        .move_dir  (move_dir),
        .move_ready(move_ready),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .moved     (moved),
        .blocked   (blocked)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mk(input int d, input int m, input int x, input int y);
        vec_t v;
        v.dir       = 2'(d);
        v.exp_moved = 1'(m);
        v.exp_x     = 4'(x);
        v.exp_y     = 4'(y);
        return v;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!move_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_avail", move_ready, 1);
    endtask

    // Drive one request, then compare the scoreboard entry two edges later.
    task automatic do_move(input vec_t v);
        vec_t e;
        int   n;
        bit   pulse;
        wait_ready();
        move_valid = 1'b1;
        move_dir   = v.dir;
        sb.push_back(v);
        @(negedge clk);
        move_valid = 1'b0;
        move_dir   = 2'($urandom_range(0, 3));
        check("ready_drop", move_ready, 0);
        @(negedge clk);
        e = sb.pop_front();
        check("moved", moved, e.exp_moved);
        check("blocked", blocked, !e.exp_moved);
        check("pos_x", pos_x, e.exp_x);
        check("pos_y", pos_y, e.exp_y);
        if (e.exp_moved) begin
            n     = 0;
            pulse = 1'b0;
            while (!move_ready && n < 300) begin
                @(negedge clk);
                n++;
                if (moved || blocked) pulse = 1'b1;
            end
            check("cooldown_len", n, CD);
            check("extra_pulse", pulse, 0);
        end else begin
            check("ready_after_block", move_ready, 1);
        end
    endtask

    task automatic watch_quiet(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check(name, moved | blocked, 0);
        end
    endtask

    initial begin
        int k_exp;
        int n_moves;

        // Request table: blocked at origin, walk to the far corner,
        // hit the far edges, then step back inward.
        vecs.push_back(mk(0, 0, 0, 0));
        vecs.push_back(mk(2, 0, 0, 0));
        for (int i = 1; i <= 9; i++) vecs.push_back(mk(3, 1, i, 0));
        for (int j = 1; j <= 9; j++) vecs.push_back(mk(1, 1, 9, j));
        vecs.push_back(mk(3, 0, 9, 9));
        vecs.push_back(mk(1, 0, 9, 9));
        vecs.push_back(mk(2, 1, 9, 8));
        vecs.push_back(mk(0, 1, 8, 8));

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pos_x", pos_x, 0);
        check("rst_pos_y", pos_y, 0);
        check("rst_ready", move_ready, 1);
        check("rst_moved", moved, 0);
        check("rst_blocked", blocked, 0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) do_move(vecs[i]);

        // Plain spawn back to the origin from (8,8)
        spawn = 1'b1;
        @(negedge clk);
        spawn = 1'b0;
        check("spawn_x", pos_x, 0);
        check("spawn_y", pos_y, 0);
        check("spawn_ready", move_ready, 1);

        // Continuous valid, dir = down: one move every 2+CD cycles
        move_dir   = 2'd1;
        move_valid = 1'b1;
        n_moves    = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            k_exp = (k >= 2 && ((k - 2) % (2 + CD)) == 0) ? 1 : 0;
            n_moves += k_exp;
            check("stream_moved", moved, k_exp);
            check("stream_blocked", blocked, 0);
        end
        move_valid = 1'b0;
        check("stream_pos_y", pos_y, n_moves);
        check("stream_pos_x", pos_x, 0);

        // Spawn on the same cycle as a handshake
        wait_ready();
        move_valid = 1'b1;
        move_dir   = 2'd3;
        spawn      = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
        spawn      = 1'b0;
        check("hs_spawn_x", pos_x, 0);
        check("hs_spawn_y", pos_y, 0);
        check("hs_spawn_ready", move_ready, 1);
        check("hs_spawn_pulse", moved | blocked, 0);
        watch_quiet("hs_spawn_quiet", 4);
        check("hs_spawn_hold_x", pos_x, 0);

        // Spawn during WAIT at (5,5)
        for (int i = 1; i <= 4; i++) do_move(mk(3, 1, i, 0));
        for (int j = 1; j <= 5; j++) do_move(mk(1, 1, 4, j));
        wait_ready();
        move_valid = 1'b1;
        move_dir   = 2'd3;
        @(negedge clk);
        move_valid = 1'b0;
        @(negedge clk);
        check("wait_moved", moved, 1);
        check("wait_pos_x", pos_x, 5);
        check("wait_pos_y", pos_y, 5);
        @(negedge clk);
        check("wait_ready_low", move_ready, 0);
        spawn = 1'b1;
        @(negedge clk);
        spawn = 1'b0;
        check("wait_spawn_x", pos_x, 0);
        check("wait_spawn_y", pos_y, 0);
        check("wait_spawn_ready", move_ready, 1);
        check("wait_spawn_pulse", moved | blocked, 0);
        watch_quiet("wait_spawn_quiet", 6);

        // Reset during EVAL at (3,3) with a right request
        for (int i = 1; i <= 3; i++) do_move(mk(3, 1, i, 0));
        for (int j = 1; j <= 3; j++) do_move(mk(1, 1, 3, j));
        wait_ready();
        move_valid = 1'b1;
        move_dir   = 2'd3;
        @(negedge clk);
        move_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("eval_rst_x", pos_x, 0);
        check("eval_rst_y", pos_y, 0);
        check("eval_rst_ready", move_ready, 1);
        check("eval_rst_moved", moved, 0);
        watch_quiet("eval_rst_quiet", 6);
        check("eval_rst_hold_x", pos_x, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
